uart_rx: RTL

UART receiver for the 8N1 link: recovers bytes from the serial `rx` line using the 16x oversampling tick (`tick_rx`) produced by `Baudrate` (50 MHz clock, 9600 baud, one tick every 325 clocks). It sits beside the UART transmitter in the UART top level. Received bytes are presented through a one-entry valid/ready holding register, with framing-error and overrun flags.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver/transmitter FSM states.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_TICK   = OVERSAMPLE / 2 - 1;
   localparam int unsigned LAST_TICK  = OVERSAMPLE - 1;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer bus: one-entry valid/ready holding register plus error pulses.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS
);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ready
   );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset to RESET_VAL.
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // rst_n is active-high here.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled start/data/stop recovery into a one-entry holding register.
module uart_rx #(
   parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS,
   parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick,
   input  logic         rx,
   output logic         busy,
   uart_rx_if.master    rx_bus
);

   import uart_pkg::*;

   localparam int unsigned TcntW = $clog2(OVERSAMPLE);
   localparam int unsigned BcntW = $clog2(DATA_BITS);
   localparam logic [TcntW-1:0] MidTick  = TcntW'(OVERSAMPLE / 2 - 1);
   localparam logic [TcntW-1:0] LastTick = TcntW'(OVERSAMPLE - 1);
   localparam logic [BcntW-1:0] LastBit  = BcntW'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_d;
   uart_state_e          state_q;
   logic [TcntW-1:0]     tcnt_q;
   logic [BcntW-1:0]     bcnt_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 ovr_q;
   logic                 busy_q;

   logic stop_hit;
   logic done;
   logic accept;

   uart_sync #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx),
      .q    (rx_s)
   );

   assign stop_hit = (state_q == StStop) && tick && (tcnt_q == LastTick);
   assign done     = stop_hit && rx_s;
   assign accept   = valid_q && rx_bus.rx_ready;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rx_d    <= 1'b1;
         state_q <= StIdle;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         rx_d   <= rx_s;
         ferr_q <= stop_hit && !rx_s;
         ovr_q  <= 1'b0;

         unique case (state_q)
            StIdle: begin
               // Edge-triggered so a held-low break cannot restart a frame.
               if (rx_d && !rx_s) begin
                  state_q <= StStart;
                  tcnt_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StStart: begin
               if (tick) begin
                  if (tcnt_q == MidTick) begin
                     tcnt_q <= '0;
                     if (rx_s) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= StData;
                        bcnt_q  <= '0;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  if (tcnt_q == LastTick) begin
                     tcnt_q  <= '0;
                     shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                     if (bcnt_q == LastBit) begin
                        state_q <= StStop;
                     end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            end
            StStop: begin
               if (tick) begin
                  if (tcnt_q == LastTick) begin
                     // Leave at mid-stop so the next start edge is not missed.
                     tcnt_q  <= '0;
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

         if (done) begin
            data_q  <= shreg_q;
            valid_q <= 1'b1;
            ovr_q   <= valid_q && !rx_bus.rx_ready;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_bus.rx_data   = data_q;
   assign rx_bus.rx_valid  = valid_q;
   assign rx_bus.frame_err = ferr_q;
   assign rx_bus.overrun   = ovr_q;
   assign busy             = busy_q;

endmodule
